// File: rtl/psum_binarizer_packer.sv
// ============================================================================
// Module      : psum_binarizer_packer
// Description : Binarizes signed partial sums against a threshold and packs
//               the bits LSB-first into words for the feature-map buffer.
//               Optional macro BINARIZER_STATS_EN adds a per-frame ones_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_binarizer_packer #(
    parameter int PSUM_DATA_WIDTH = 12,
    parameter int PACK_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 10,
    parameter int COUNT_WIDTH     = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COUNT_WIDTH-1:0]     num_values,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [PSUM_DATA_WIDTH-1:0] threshold,
    input  logic [PSUM_DATA_WIDTH-1:0] in_psum,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [PACK_WIDTH-1:0]      wr_data,
    output logic                       wr_last,
    output logic                       busy,
    output logic                       done
`ifdef BINARIZER_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0]     ones_count
`endif
);

    localparam int IDX_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [COUNT_WIDTH-1:0]       r_remaining;
    logic [IDX_W-1:0]             r_bit_idx;
    logic [PACK_WIDTH-1:0]        r_pack;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic [PSUM_DATA_WIDTH-1:0]   r_threshold;

    logic w_accept;
    logic w_bit;
    logic w_word_full;
    logic w_frame_end;
    logic w_wr_fire;

    assign w_accept    = in_valid && (r_state == S_COLLECT);
    assign w_bit       = ($signed(in_psum) >= $signed(r_threshold));
    assign w_word_full = (r_bit_idx == IDX_W'(PACK_WIDTH - 1));
    assign w_frame_end = (r_remaining == COUNT_WIDTH'(1));
    assign w_wr_fire   = (r_state == S_WRITE) && wr_ready;

    assign wr_addr = r_addr;
    assign wr_data = r_pack;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        wr_valid     = 1'b0;
        wr_last      = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_values == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (w_accept && (w_word_full || w_frame_end)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_valid = 1'b1;
                wr_last  = (r_remaining == '0);
                if (w_wr_fire) begin
                    w_state_next = (r_remaining == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_bit_idx   <= '0;
            r_pack      <= '0;
            r_addr      <= '0;
            r_threshold <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    // Frame parameters are captured once; later changes are ignored
                    if (start) begin
                        r_remaining <= num_values;
                        r_addr      <= base_addr;
                        r_threshold <= threshold;
                        r_pack      <= '0;
                        r_bit_idx   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_pack[r_bit_idx] <= w_bit;
                        r_bit_idx         <= w_word_full ? '0 : r_bit_idx + IDX_W'(1);
                        r_remaining       <= r_remaining - COUNT_WIDTH'(1);
                    end
                end
                S_WRITE: begin
                    if (w_wr_fire) begin
                        r_addr    <= r_addr + ADDR_WIDTH'(1);
                        r_pack    <= '0;
                        r_bit_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BINARIZER_STATS_EN
    logic [COUNT_WIDTH-1:0] r_ones;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ones <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_ones <= '0;
        end else if (w_accept && w_bit) begin
            r_ones <= r_ones + COUNT_WIDTH'(1);
        end
    end

    assign ones_count = r_ones;
`endif

endmodule

`default_nettype wire
